// File: rtl/bus_seq_checker.sv
// bus_seq_checker: predicts the next word of an incrementing-counter bus, locks on agreement, and logs errors and wraps
module bus_seq_checker #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int SYNC_LOCK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              bus_enable,
  input  logic              clr,
  output logic              locked,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  wrap_cnt,
  output logic [DATA_W-1:0] exp_data,
  output logic [DATA_W-1:0] act_data
);
  localparam int MW = $clog2(SYNC_LOCK + 1);
  localparam logic [MW:0] LOCK_N = (MW + 1)'(SYNC_LOCK);
  localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   prev_data_q;
  logic                prev_en_q;
  logic [MW-1:0]       mcnt_q, mcnt_d;
  logic                err_flag_q, err_flag_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d, wrap_cnt_q, wrap_cnt_d;
  logic [DATA_W-1:0]   exp_q, exp_d, act_q, act_d;
  logic [DATA_W-1:0]   expected;
  logic [MW:0]         mcnt_inc;
  logic                match, err, wrap, lock_hit;

  assign expected = prev_en_q ? prev_data_q + ONE_D : '0;
  assign match    = bus_data == expected;
  assign mcnt_inc = {1'b0, mcnt_q} + {{MW{1'b0}}, 1'b1};
  assign lock_hit = match && mcnt_inc >= LOCK_N;
  assign err      = state_q == LOCK && !match;
  assign wrap     = state_q != IDLE && prev_en_q && &prev_data_q && bus_data == '0;

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  // Next state: first sample only primes the predictor, then acquire until enough matches
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ACQ;
      ACQ:     state_d = lock_hit ? LOCK : ACQ;
      LOCK:    state_d = match ? LOCK : ACQ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; an error on the same edge as clr takes precedence over the clear
  always_comb begin
    mcnt_d     = (state_q == ACQ && match && !lock_hit) ? mcnt_inc[MW-1:0] : '0;
    err_flag_d = err ? 1'b1 : clr ? 1'b0 : err_flag_q;
    err_cnt_d  = err ? (clr ? ONE_C : &err_cnt_q ? err_cnt_q : err_cnt_q + ONE_C)
               : clr ? '0 : err_cnt_q;
    wrap_cnt_d = wrap ? (clr ? ONE_C : wrap_cnt_q + ONE_C) : clr ? '0 : wrap_cnt_q;
    exp_d      = err ? expected : exp_q;
    act_d      = err ? bus_data : act_q;
  end

  // Datapath registers; the previous sample is tracked in every state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_data_q <= '0;
      prev_en_q   <= 1'b0;
      mcnt_q      <= '0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      exp_q       <= '0;
      act_q       <= '0;
    end else begin
      prev_data_q <= bus_data;
      prev_en_q   <= bus_enable;
      mcnt_q      <= mcnt_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      exp_q       <= exp_d;
      act_q       <= act_d;
    end

  assign locked   = state_q == LOCK;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;
  assign exp_data = exp_q;
  assign act_data = act_q;
endmodule

// File: tb/tb_bus_seq_checker.sv
// tb_bus_seq_checker: scoreboard bench for bus_seq_checker (default and 4-bit counter instances)
module tb_bus_seq_checker;
  logic clk = 0, rst_n = 0, en = 0, clr = 0;
  logic [7:0] d = 0;
  logic lk, fl, lk4, fl4;
  logic [15:0] ec, wc;
  logic [3:0] ec4, wc4;
  logic [7:0] ex, ac, ex4, ac4;

  typedef struct packed {
    logic lk, fl;
    logic [15:0] ec, wc;
    logic [7:0] ex, ac;
  } exp_t;
  exp_t q[$];

  logic e_lk = 0, e_fl = 0;
  logic [15:0] e_ec = 0, e_wc = 0;
  logic [7:0] e_ex = 0, e_ac = 0;
  int checks = 0, failures = 0;

  bus_seq_checker dut (.clk(clk), .rst_n(rst_n), .bus_data(d), .bus_enable(en), .clr(clr),
    .locked(lk), .err_flag(fl), .err_cnt(ec), .wrap_cnt(wc), .exp_data(ex), .act_data(ac));

  bus_seq_checker #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus_data(d), .bus_enable(en), .clr(clr),
    .locked(lk4), .err_flag(fl4), .err_cnt(ec4), .wrap_cnt(wc4), .exp_data(ex4), .act_data(ac4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    chk("locked", 16'(lk), 16'(e.lk));
    chk("err_flag", 16'(fl), 16'(e.fl));
    chk("err_cnt", ec, e.ec);
    chk("wrap_cnt", wc, e.wc);
    chk("exp_data", 16'(ex), 16'(e.ex));
    chk("act_data", 16'(ac), 16'(e.ac));
    chk("locked4", 16'(lk4), 16'(e.lk));
    chk("err_flag4", 16'(fl4), 16'(e.fl));
    chk("err_cnt4", 16'(ec4), e.ec > 16'd15 ? 16'd15 : e.ec);
    chk("wrap_cnt4", 16'(wc4), {12'd0, e.wc[3:0]});
    chk("exp_data4", 16'(ex4), 16'(e.ex));
    chk("act_data4", 16'(ac4), 16'(e.ac));
  endtask

  task automatic step(input logic [7:0] dv, input logic ev, input logic cv);
    @(negedge clk);
    d = dv; en = ev; clr = cv;
    @(posedge clk);
    #1 q.push_back({e_lk, e_fl, e_ec, e_wc, e_ex, e_ac});
  endtask

  always @(negedge clk)
    if (q.size() != 0) cmp_all(q.pop_front());

  initial begin
    logic [7:0] cur;
    #3 cmp_all('0);
    @(posedge clk);
    #1 rst_n = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    e_lk = 1; step(0, 1, 0);
    step(1, 1, 0); step(2, 1, 0); step(3, 1, 0); step(4, 1, 0);
    e_lk = 0; e_fl = 1; e_ec = 1; e_ex = 8'h05; e_ac = 8'h07; step(8'h07, 1, 0);
    step(8'h08, 1, 0);
    e_lk = 1; step(8'h09, 1, 0);
    step(8'h0a, 1, 0);
    e_lk = 0; e_ex = 8'h0b; e_ac = 8'h20; step(8'h20, 1, 1);
    e_fl = 0; e_ec = 0; step(8'h21, 1, 1);
    e_lk = 1; step(8'h22, 1, 0);
    step(8'h23, 0, 0);
    step(8'h00, 1, 0);
    for (int i = 1; i <= 300; i++) begin
      if (i == 256) e_wc = 1;
      step(8'(i), 1, 0);
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1 cmp_all('0);
    e_lk = 0; e_fl = 0; e_ec = 0; e_wc = 0; e_ex = 0; e_ac = 0;
    @(posedge clk);
    #1 rst_n = 1;
    step(5, 1, 0); step(6, 1, 0);
    e_lk = 1; step(7, 1, 0);
    cur = 7;
    for (int k = 1; k <= 20; k++) begin
      e_lk = 0; e_fl = 1; e_ec = 16'(k); e_ex = cur + 8'd1; e_ac = cur + 8'd3;
      step(cur + 8'd3, 1, 0);
      step(cur + 8'd4, 1, 0);
      e_lk = 1; step(cur + 8'd5, 1, 0);
      cur = cur + 8'd5;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
